// File: rtl/ntt_pkg.sv
// Shared constants for the Kyber NTT datapath (q = 3329) and the optional
// per-layer halving used when GS_HALVE_EN folds n^-1 into the inverse NTT.
package ntt_pkg;

   localparam int              DATA_W    = 12;
   localparam logic [DATA_W-1:0] Q       = 12'd3329;
   localparam int              BARRETT_M = 5039;
   localparam int              BARRETT_K = 24;
   localparam int              PROD_W    = 24;

   // v/2 mod q for v < q: odd values borrow a q to become even first.
   function automatic logic [DATA_W-1:0] halve(input logic [DATA_W-1:0] v);
      return v[0] ? DATA_W'(({1'b0, v} + {1'b0, Q}) >> 1) : (v >> 1);
   endfunction

endpackage

// File: rtl/gs_butterfly_pipe_if.sv
// Coefficient-in / result-out handshake bundle for the GS butterfly.
interface gs_butterfly_pipe_if;
   import ntt_pkg::*;

   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] a_in;
   logic [DATA_W-1:0] b_in;
   logic [DATA_W-1:0] w_in;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] x_out;
   logic [DATA_W-1:0] y_out;

   modport master (
      output in_valid, a_in, b_in, w_in, out_ready,
      input  in_ready, out_valid, x_out, y_out
   );

   modport slave (
      input  in_valid, a_in, b_in, w_in, out_ready,
      output in_ready, out_valid, x_out, y_out
   );

endinterface

// File: rtl/gs_barrett_reduce.sv
// Two-stage registered Barrett reduction of a 24-bit product mod q.
// Stage A registers the quotient estimate and p; stage B subtracts and folds once.
module gs_barrett_reduce
   import ntt_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic [PROD_W-1:0] p_in,
   output logic [DATA_W-1:0] r_out
);

   localparam int PM_W = PROD_W + 13;

   logic [DATA_W-1:0] w_t;
   logic [DATA_W:0]   w_r;
   logic [DATA_W-1:0] w_y;
   logic [DATA_W-1:0] r_t;
   logic [PROD_W-1:0] r_p;

   // t underestimates p/q by at most one, so r lands in [0, 2q) and fits 13 bits.
   always_comb begin
      w_t = DATA_W'((PM_W'(p_in) * PM_W'(BARRETT_M)) >> BARRETT_K);
      w_r = (DATA_W+1)'(r_p) - ((DATA_W+1)'(r_t) * (DATA_W+1)'(Q));
      w_y = (w_r >= {1'b0, Q}) ? DATA_W'(w_r - {1'b0, Q}) : DATA_W'(w_r);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_t   <= '0;
         r_p   <= '0;
         r_out <= '0;
      end else if (en) begin
         r_t   <= w_t;
         r_p   <= p_in;
         r_out <= w_y;
      end
   end

endmodule

// File: rtl/gs_butterfly_pipe.sv
// Four-stage Gentleman-Sande butterfly for the Kyber INTT: x = a+b, y = (a-b)*w mod q.
// Define GS_HALVE_EN to halve sum and difference in stage 1 (folds n^-1 per layer).
module gs_butterfly_pipe
   import ntt_pkg::*;
#(
   parameter int                    data_width = DATA_W,
   parameter logic [data_width-1:0] M          = Q
) (
   input  logic                clk,
   input  logic                rst,
   gs_butterfly_pipe_if.slave  bus
);

   logic                  w_en;
   logic [data_width:0]   w_s;
   logic [data_width-1:0] w_sum;
   logic [data_width-1:0] w_diff;
   logic [data_width-1:0] w_y;

   logic                  r_v1, r_v2, r_v3, r_v4;
   logic [data_width-1:0] r_sum1, r_diff1, r_w1;
   logic [PROD_W-1:0]     r_p2;
   logic [data_width-1:0] r_sum2, r_sum3, r_x4;

   // Whole pipe advances together; bubbles are kept, not squeezed out.
   assign w_en          = ~r_v4 | bus.out_ready;
   assign bus.in_ready  = w_en;
   assign bus.out_valid = r_v4;
   assign bus.x_out     = r_x4;
   assign bus.y_out     = w_y;

   always_comb begin
      w_s    = {1'b0, bus.a_in} + {1'b0, bus.b_in};
      w_sum  = (w_s >= {1'b0, M}) ? data_width'(w_s - {1'b0, M}) : data_width'(w_s);
      w_diff = (bus.a_in >= bus.b_in) ? bus.a_in - bus.b_in : bus.a_in - bus.b_in + M;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_v1    <= 1'b0;
         r_v2    <= 1'b0;
         r_v3    <= 1'b0;
         r_v4    <= 1'b0;
         r_sum1  <= '0;
         r_diff1 <= '0;
         r_w1    <= '0;
         r_p2    <= '0;
         r_sum2  <= '0;
         r_sum3  <= '0;
         r_x4    <= '0;
      end else if (w_en) begin
         r_v1    <= bus.in_valid;
`ifdef GS_HALVE_EN
         r_sum1  <= halve(w_sum);
         r_diff1 <= halve(w_diff);
`else
         r_sum1  <= w_sum;
         r_diff1 <= w_diff;
`endif
         r_w1    <= bus.w_in;
         r_v2    <= r_v1;
         r_p2    <= PROD_W'(r_diff1) * PROD_W'(r_w1);
         r_sum2  <= r_sum1;
         r_v3    <= r_v2;
         r_sum3  <= r_sum2;
         r_v4    <= r_v3;
         r_x4    <= r_sum3;
      end
   end

   gs_barrett_reduce u_reduce (
      .clk   (clk),
      .rst   (rst),
      .en    (w_en),
      .p_in  (r_p2),
      .r_out (w_y)
   );

endmodule

// File: tb/tb_gs_butterfly_pipe.sv
// Self-checking bench for gs_butterfly_pipe: directed vectors, random traffic with
// stalls against a modular-arithmetic reference, and mid-stream reset.
module tb_gs_butterfly_pipe;
   import ntt_pkg::*;

   localparam int QI   = 3329;
   localparam int INV2 = 1665;

   typedef struct {int x; int y;} exp_t;
   typedef struct {int a; int b; int w; int x; int y;} vec_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   gs_butterfly_pipe_if bus ();

   gs_butterfly_pipe dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   exp_t sb[$];
   vec_t vt[$];
   int   errors = 0;
   int   checks = 0;
   bit   mon_en = 1'b0;

   function automatic exp_t model(input int a, input int b, input int w);
      exp_t e;
      int s, d;
      s = (a + b) % QI;
      d = (a - b + QI) % QI;
`ifdef GS_HALVE_EN
      s = (s * INV2) % QI;
      d = (d * INV2) % QI;
`endif
      e.x = s;
      e.y = (d * w) % QI;
      return e;
   endfunction

   function automatic vec_t mk(input int a, input int b, input int w, input int x, input int y);
      vec_t v;
      v.a = a; v.b = b; v.w = w; v.x = x; v.y = y;
      return v;
   endfunction

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input int a, input int b, input int w);
      bus.in_valid = 1'b1;
      bus.a_in     = 12'(a);
      bus.b_in     = 12'(b);
      bus.w_in     = 12'(w);
   endtask

   // Scoreboard: record accepted beats and compare delivered ones in order.
   always @(negedge clk) begin
      exp_t e;
      if (mon_en) begin
         if (rst) begin
            sb.delete();
         end else begin
            if (bus.out_valid && bus.out_ready) begin
               if (sb.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL stale_beat: got x=%0d y=%0d with nothing outstanding", bus.x_out, bus.y_out);
               end else begin
                  e = sb.pop_front();
                  check("x_model", int'(bus.x_out), e.x);
                  check("y_model", int'(bus.y_out), e.y);
               end
            end
            if (bus.in_valid && bus.in_ready)
               sb.push_back(model(int'(bus.a_in), int'(bus.b_in), int'(bus.w_in)));
         end
      end
   end

   initial begin
      int n, idle, seen;
      exp_t head;

`ifdef GS_HALVE_EN
      vt.push_back(mk(1, 0, 1, 1665, 1665));
      vt.push_back(mk(4, 2, 3, 3, 3));
      vt.push_back(mk(3328, 0, 3328, 1664, 1665));
`else
      vt.push_back(mk(5, 3, 1, 8, 2));
      vt.push_back(mk(0, 1, 1, 1, 3328));
      vt.push_back(mk(3328, 3328, 7, 3327, 0));
      vt.push_back(mk(3328, 0, 3328, 3328, 1));
`endif

      rst           = 1'b1;
      bus.in_valid  = 1'b0;
      bus.a_in      = '0;
      bus.b_in      = '0;
      bus.w_in      = '0;
      bus.out_ready = 1'b1;
      repeat (3) tick();
      check("rst_out_valid", int'(bus.out_valid), 0);
      check("rst_x", int'(bus.x_out), 0);
      check("rst_y", int'(bus.y_out), 0);
      check("rst_in_ready", int'(bus.in_ready), 1);
      rst    = 1'b0;
      mon_en = 1'b1;
      tick();

      // Directed vectors, one at a time so latency is visible.
      foreach (vt[i]) begin
         drive(vt[i].a, vt[i].b, vt[i].w);
         #1;
         check("idle_in_ready", int'(bus.in_ready), 1);
         tick();
         bus.in_valid = 1'b0;
         n = 1;
         while (!bus.out_valid && n < 12) begin
            tick();
            n++;
         end
         check("latency", n, 4);
         check("x_vec", int'(bus.x_out), vt[i].x);
         check("y_vec", int'(bus.y_out), vt[i].y);
         tick();
      end

      // 1000 back-to-back random beats with out_ready held high.
      idle = 0;
      for (int i = 0; i < 1000; i++) begin
         drive($urandom_range(QI - 1, 0), $urandom_range(QI - 1, 0), $urandom_range(QI - 1, 0));
         #1;
         if (!bus.in_ready) idle++;
         tick();
      end
      bus.in_valid = 1'b0;
      check("idle_cycles", idle, 0);
      repeat (8) tick();
      check("drain_b2b", sb.size(), 0);

      // Fill the pipe, then hold out_ready low for 5 cycles.
      for (int i = 0; i < 6; i++) begin
         drive($urandom_range(QI - 1, 0), $urandom_range(QI - 1, 0), $urandom_range(QI - 1, 0));
         tick();
      end
      drive(1234, 2345, 999);
      bus.out_ready = 1'b0;
      #1;
      head = sb[0];
      for (int i = 0; i < 5; i++) begin
         check("stall_in_ready", int'(bus.in_ready), 0);
         check("stall_out_valid", int'(bus.out_valid), 1);
         check("stall_x", int'(bus.x_out), head.x);
         check("stall_y", int'(bus.y_out), head.y);
         tick();
      end
      bus.out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         drive($urandom_range(QI - 1, 0), $urandom_range(QI - 1, 0), $urandom_range(QI - 1, 0));
         tick();
      end
      bus.in_valid = 1'b0;
      repeat (10) tick();
      check("drain_stall", sb.size(), 0);

      // Random valid and random back-pressure.
      for (int i = 0; i < 400; i++) begin
         drive($urandom_range(QI - 1, 0), $urandom_range(QI - 1, 0), $urandom_range(QI - 1, 0));
         bus.in_valid  = ($urandom_range(2, 0) != 0);
         bus.out_ready = ($urandom_range(3, 0) != 0);
         tick();
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      repeat (10) tick();
      check("drain_random", sb.size(), 0);

      // Reset with three beats in flight.
      for (int i = 0; i < 3; i++) begin
         drive($urandom_range(QI - 1, 0), $urandom_range(QI - 1, 0), $urandom_range(QI - 1, 0));
         tick();
      end
      bus.in_valid = 1'b0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("midrst_out_valid", int'(bus.out_valid), 0);
      check("midrst_in_ready", int'(bus.in_ready), 1);
      seen = 0;
      for (int i = 0; i < 8; i++) begin
         tick();
         if (bus.out_valid) seen++;
      end
      check("post_rst_valid_cycles", seen, 0);

      // Pipe still usable after reset.
      drive(vt[0].a, vt[0].b, vt[0].w);
      tick();
      bus.in_valid = 1'b0;
      n = 1;
      while (!bus.out_valid && n < 12) begin
         tick();
         n++;
      end
      check("post_rst_latency", n, 4);
      check("post_rst_x", int'(bus.x_out), vt[0].x);
      check("post_rst_y", int'(bus.y_out), vt[0].y);
      repeat (3) tick();
      check("drain_final", sb.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
